uart_axi_lite_regs: RTL



---
 rtl/uart_axi_lite_regs.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_axi_lite_regs.sv
// AXI-lite register front-end for the UART: DATA/STATUS/CTRL decode plus a TX byte FIFO
// that drains to the serializer over a valid/ready byte stream.
module uart_axi_lite_regs #(
  parameter int         AXI_ADDR_W = 32,
  parameter int         AXI_DATA_W = 32,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] OFS_DATA   = 8'h00,
  parameter logic [7:0] OFS_STATUS = 8'h04,
  parameter logic [7:0] OFS_CTRL   = 8'h08
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [AXI_ADDR_W-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [AXI_DATA_W-1:0] s_wdata,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [AXI_ADDR_W-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [AXI_DATA_W-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int         IDX_W       = $clog2(FIFO_DEPTH);
  localparam int         PTR_W       = IDX_W + 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {SEL_DATA, SEL_STATUS, SEL_CTRL, SEL_NONE} reg_sel_e;

  function automatic reg_sel_e decode(input logic [7:0] ofs);
    if (ofs == OFS_DATA)   return SEL_DATA;
    if (ofs == OFS_STATUS) return SEL_STATUS;
    if (ofs == OFS_CTRL)   return SEL_CTRL;
    return SEL_NONE;
  endfunction

  logic                  aw_held, w_held;
  logic [7:0]            waddr_q, wdata_q;
  logic                  enable, overflow;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr, rd_ptr_nxt, count;
  logic [7:0]            mem [FIFO_DEPTH];
  logic [7:0]            head_nxt;
  logic                  full, empty, push, pop, flush, wr_exec;
  reg_sel_e              wr_sel, rd_sel;
  logic [1:0]            wr_resp, rd_resp;
  logic [AXI_DATA_W-1:0] rd_data;
  logic                  unused_bits;

  // Only the low address byte is decoded and only the low data byte is ever stored.
  assign unused_bits = ^{s_awaddr[AXI_ADDR_W-1:8], s_araddr[AXI_ADDR_W-1:8],
                         s_wdata[AXI_DATA_W-1:8]};

  assign s_awready = !aw_held;
  assign s_wready  = !w_held;
  assign s_arready = !s_rvalid;

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == PTR_W'(FIFO_DEPTH));
  assign empty    = (wr_ptr == rd_ptr);
  assign tx_valid = !empty && enable;

  assign wr_exec = aw_held && w_held && !s_bvalid;
  assign wr_sel  = decode(waddr_q);
  assign rd_sel  = decode(s_araddr[7:0]);
  assign push    = wr_exec && (wr_sel == SEL_DATA) && !full;
  assign flush   = wr_exec && (wr_sel == SEL_CTRL) && wdata_q[1];
  assign pop     = tx_valid && tx_ready;
  assign wr_resp = ((wr_sel == SEL_NONE) || ((wr_sel == SEL_DATA) && full)) ? RESP_SLVERR
                                                                           : RESP_OKAY;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      s_bvalid <= 1'b0;
      s_bresp  <= RESP_OKAY;
    end else begin
      if (s_awvalid && s_awready) begin
        aw_held <= 1'b1;
        waddr_q <= s_awaddr[7:0];
      end
      if (s_wvalid && s_wready) begin
        w_held  <= 1'b1;
        wdata_q <= s_wdata[7:0];
      end
      if (wr_exec) begin
        s_bvalid <= 1'b1;
        s_bresp  <= wr_resp;
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable   <= 1'b1;
      overflow <= 1'b0;
    end else if (wr_exec) begin
      if ((wr_sel == SEL_DATA) && full) overflow <= 1'b1;
      if (wr_sel == SEL_CTRL) begin
        enable <= wdata_q[0];
        if (wdata_q[2]) overflow <= 1'b0;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    if (flush)    rd_ptr_nxt = wr_ptr;
    else if (pop) rd_ptr_nxt = rd_ptr + PTR_W'(1);
    // Bypass the array when the incoming byte becomes the new head, so there is no bubble.
    head_nxt = (push && (wr_ptr == rd_ptr_nxt)) ? wdata_q : mem[rd_ptr_nxt[IDX_W-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tx_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr  <= rd_ptr_nxt;
      tx_data <= head_nxt;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IDX_W-1:0]] <= wdata_q;
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_sel)
      SEL_STATUS: begin
        rd_data[0]    = full;
        rd_data[1]    = empty;
        rd_data[2]    = overflow;
        rd_data[3]    = enable;
        rd_data[15:8] = 8'(count);
      end
      SEL_CTRL: rd_data[0] = enable;
      SEL_NONE: rd_resp = RESP_SLVERR;
      default:  rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
    end else if (s_arvalid && s_arready) begin
      s_rvalid <= 1'b1;
      s_rdata  <= rd_data;
      s_rresp  <= rd_resp;
    end else if (s_rvalid && s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

endmodule
